// File: rtl/alu_result_checker.sv
// alu_result_checker: compares an ALU-under-test result against a golden model, counts samples and mismatches
module alu_result_checker #(
  parameter bit STOP_ON_ERR = 1'b0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic [1:0]       op,
  input  logic [3:0]       dut_out,
  input  logic             clr,
  output logic             chk_valid,
  output logic             chk_pass,
  output logic [3:0]       expected,
  output logic [CNT_W-1:0] total_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_sticky,
  output logic [3:0]       first_err_a,
  output logic [3:0]       first_err_b,
  output logic [3:0]       first_err_got,
  output logic [1:0]       first_err_op
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_nxt;
  logic [3:0] gold;
  logic xfer, mism;
  always_comb begin
    gold = op == 2'd0 ? a + b : op == 2'd1 ? a - b : op == 2'd2 ? a & b : a | b;
    in_ready = state == RUN;
    xfer = in_valid && in_ready && !clr;
    mism = dut_out != gold;
    state_nxt = clr ? RUN : (xfer && mism && STOP_ON_ERR) ? HALT : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      chk_valid <= 1'b0;
      chk_pass <= 1'b0;
      expected <= '0;
      total_count <= '0;
      err_count <= '0;
      err_sticky <= 1'b0;
      first_err_a <= '0;
      first_err_b <= '0;
      first_err_got <= '0;
      first_err_op <= '0;
    end else begin
      state <= state_nxt;
      chk_valid <= xfer;
      if (clr) begin
        total_count <= '0;
        err_count <= '0;
        err_sticky <= 1'b0;
        first_err_a <= '0;
        first_err_b <= '0;
        first_err_got <= '0;
        first_err_op <= '0;
      end else if (xfer) begin
        expected <= gold;
        chk_pass <= !mism;
        total_count <= total_count == '1 ? total_count : total_count + 1'b1;
        if (mism) err_count <= err_count == '1 ? err_count : err_count + 1'b1;
        if (mism && !err_sticky) begin
          err_sticky <= 1'b1;
          first_err_a <= a;
          first_err_b <= b;
          first_err_got <= dut_out;
          first_err_op <= op;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker: directed vector table plus hand-written sequences for halt, saturation, clr and reset
module tb_alu_result_checker;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] a = '0, b = '0, dout = '0;
  logic [1:0] op = '0;
  logic [2:0] iv = '0, cl = '0;
  logic [2:0] rdy, cv, cp, st;
  logic [3:0] ex [3];
  logic [3:0] fa [3];
  logic [3:0] fb [3];
  logic [3:0] fg [3];
  logic [1:0] fo [3];
  logic [7:0] tc0, ec0, tc1, ec1;
  logic [3:0] tc2, ec2;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  alu_result_checker u0 (.clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]), .a(a), .b(b), .op(op),
    .dut_out(dout), .clr(cl[0]), .chk_valid(cv[0]), .chk_pass(cp[0]), .expected(ex[0]), .total_count(tc0),
    .err_count(ec0), .err_sticky(st[0]), .first_err_a(fa[0]), .first_err_b(fb[0]), .first_err_got(fg[0]),
    .first_err_op(fo[0]));
  alu_result_checker #(.STOP_ON_ERR(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]),
    .a(a), .b(b), .op(op), .dut_out(dout), .clr(cl[1]), .chk_valid(cv[1]), .chk_pass(cp[1]), .expected(ex[1]),
    .total_count(tc1), .err_count(ec1), .err_sticky(st[1]), .first_err_a(fa[1]), .first_err_b(fb[1]),
    .first_err_got(fg[1]), .first_err_op(fo[1]));
  alu_result_checker #(.CNT_W(4)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy[2]),
    .a(a), .b(b), .op(op), .dut_out(dout), .clr(cl[2]), .chk_valid(cv[2]), .chk_pass(cp[2]), .expected(ex[2]),
    .total_count(tc2), .err_count(ec2), .err_sticky(st[2]), .first_err_a(fa[2]), .first_err_b(fb[2]),
    .first_err_got(fg[2]), .first_err_op(fo[2]));

  typedef struct {
    logic [3:0] a, b;
    logic [1:0] op;
    logic [3:0] d, e;
    logic p;
  } vec_t;
  vec_t v [12];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", n, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] na, nb, input logic [1:0] nop, input logic [3:0] nd);
    a = na; b = nb; op = nop; dout = nd;
  endtask

  initial begin
    int errs;
    v[0]  = '{4'd5,  4'd3,  2'd0, 4'd8,  4'd8,  1'b1};
    v[1]  = '{4'd5,  4'd3,  2'd1, 4'd2,  4'd2,  1'b1};
    v[2]  = '{4'd5,  4'd3,  2'd2, 4'd1,  4'd1,  1'b1};
    v[3]  = '{4'd5,  4'd3,  2'd3, 4'd7,  4'd7,  1'b1};
    v[4]  = '{4'd12, 4'd7,  2'd0, 4'd3,  4'd3,  1'b1};
    v[5]  = '{4'd12, 4'd7,  2'd1, 4'd5,  4'd5,  1'b1};
    v[6]  = '{4'd0,  4'd1,  2'd1, 4'd15, 4'd15, 1'b1};
    v[7]  = '{4'd15, 4'd15, 2'd0, 4'd14, 4'd14, 1'b1};
    v[8]  = '{4'd10, 4'd5,  2'd2, 4'd0,  4'd0,  1'b1};
    v[9]  = '{4'd10, 4'd5,  2'd3, 4'd15, 4'd15, 1'b1};
    v[10] = '{4'd5,  4'd3,  2'd1, 4'd14, 4'd2,  1'b0};
    v[11] = '{4'd9,  4'd9,  2'd0, 4'd0,  4'd2,  1'b0};

    tick; tick;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", rdy[k], 1);
      chk("rst_valid", cv[k], 0);
      chk("rst_pass", cp[k], 0);
      chk("rst_expected", ex[k], 0);
      chk("rst_sticky", st[k], 0);
    end
    chk("rst_total", tc0, 0);
    chk("rst_err", ec0, 0);

    errs = 0;
    iv[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(v[i].a, v[i].b, v[i].op, v[i].d);
      tick;
      if (!v[i].p) errs++;
      chk($sformatf("vec%0d_valid", i), cv[0], 1);
      chk($sformatf("vec%0d_expected", i), ex[0], v[i].e);
      chk($sformatf("vec%0d_pass", i), cp[0], v[i].p);
      chk($sformatf("vec%0d_total", i), tc0, i + 1);
      chk($sformatf("vec%0d_err", i), ec0, errs);
    end
    iv[0] = 1'b0;
    chk("first_a", fa[0], 5);
    chk("first_b", fb[0], 3);
    chk("first_op", fo[0], 1);
    chk("first_got", fg[0], 14);
    chk("sticky", st[0], 1);
    drive(4'd1, 4'd1, 2'd0, 4'd2);
    tick;
    chk("idle_valid", cv[0], 0);
    chk("hold_expected", ex[0], 2);
    chk("hold_pass", cp[0], 0);

    iv[0] = 1'b1; cl[0] = 1'b1;
    tick;
    iv[0] = 1'b0; cl[0] = 1'b0;
    chk("clr_valid", cv[0], 0);
    chk("clr_total", tc0, 0);
    chk("clr_err", ec0, 0);
    chk("clr_sticky", st[0], 0);
    chk("clr_first_got", fg[0], 0);

    iv[1] = 1'b1;
    drive(4'd5, 4'd3, 2'd1, 4'd14);
    tick;
    chk("halt_valid", cv[1], 1);
    chk("halt_pass", cp[1], 0);
    chk("halt_ready", rdy[1], 0);
    drive(4'd5, 4'd3, 2'd0, 4'd8);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("halt_novalid", cv[1], 0);
      chk("halt_ready_held", rdy[1], 0);
    end
    chk("halt_total", tc1, 1);
    iv[1] = 1'b0; cl[1] = 1'b1;
    tick;
    cl[1] = 1'b0;
    chk("unhalt_ready", rdy[1], 1);
    chk("unhalt_total", tc1, 0);
    chk("unhalt_err", ec1, 0);
    iv[1] = 1'b1;
    tick;
    iv[1] = 1'b0;
    chk("resume_valid", cv[1], 1);
    chk("resume_pass", cp[1], 1);

    iv[2] = 1'b1;
    drive(4'd5, 4'd3, 2'd1, 4'd14);
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (i == 15 || i == 20) begin
        chk($sformatf("sat%0d_total", i), tc2, 15);
        chk($sformatf("sat%0d_err", i), ec2, 15);
      end
    end
    iv[2] = 1'b0;

    iv[0] = 1'b1;
    drive(4'd2, 4'd2, 2'd0, 4'd4);
    tick;
    chk("pre_rst_total", tc0, 1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1; iv[0] = 1'b0;
    chk("midrst_valid", cv[0], 0);
    chk("midrst_total", tc0, 0);
    chk("midrst_expected", ex[0], 0);
    chk("midrst_sat_total", tc2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
